// File: rtl/nios2_uart_rx_pi.sv
// Avalon-MM receive port: UART words are queued in a small FIFO that the CPU
// drains through DATA, with sticky overrun reporting and a maskable level interrupt.
module nios2_uart_rx_pi #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 4
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [1:0]            address,
  input  logic                  chipselect,
  input  logic                  read_n,
  input  logic                  write_n,
  input  logic [31:0]           writedata,
  output logic [31:0]           readdata,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_valid,
  output logic                  irq
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  localparam logic [1:0] ADDR_DATA   = 2'd0;
  localparam logic [1:0] ADDR_STATUS = 2'd1;
  localparam logic [1:0] ADDR_MASK   = 2'd2;

  logic [DATA_WIDTH-1:0] mem_reg [DEPTH];
  logic [PTR_W-1:0]      rd_ptr_reg, rd_ptr_next;
  logic [PTR_W-1:0]      wr_ptr_reg, wr_ptr_next;
  logic [CNT_W-1:0]      count_reg, count_next;
  logic                  overrun_reg, overrun_next;
  logic [1:0]            mask_reg, mask_next;

  logic bus_rd, bus_wr;
  logic not_empty, full;
  logic pop, push, drop;
  logic ovr_clear;

  assign bus_rd    = chipselect & ~read_n;
  assign bus_wr    = chipselect & ~write_n;
  assign not_empty = (count_reg != '0);
  assign full      = (count_reg == CNT_W'(DEPTH));

  // A pop in the same cycle frees the slot, so a push into a full FIFO is still accepted.
  assign pop       = bus_rd & (address == ADDR_DATA) & not_empty;
  assign push      = in_valid & (~full | pop);
  assign drop      = in_valid & full & ~pop;
  assign ovr_clear = bus_wr & (address == ADDR_STATUS) & writedata[1];

  always_comb begin
    rd_ptr_next  = rd_ptr_reg;
    wr_ptr_next  = wr_ptr_reg;
    count_next   = count_reg;
    overrun_next = overrun_reg;
    mask_next    = mask_reg;

    if (pop)
      rd_ptr_next = rd_ptr_reg + PTR_W'(1);
    if (push)
      wr_ptr_next = wr_ptr_reg + PTR_W'(1);

    case ({push, pop})
      2'b10:   count_next = count_reg + CNT_W'(1);
      2'b01:   count_next = count_reg - CNT_W'(1);
      default: count_next = count_reg;
    endcase

    // A new overrun in the clearing cycle must not be lost.
    if (drop)
      overrun_next = 1'b1;
    else if (ovr_clear)
      overrun_next = 1'b0;

    if (bus_wr && address == ADDR_MASK)
      mask_next = writedata[1:0];
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_ptr_reg  <= '0;
      wr_ptr_reg  <= '0;
      count_reg   <= '0;
      overrun_reg <= 1'b0;
      mask_reg    <= 2'b00;
    end else begin
      rd_ptr_reg  <= rd_ptr_next;
      wr_ptr_reg  <= wr_ptr_next;
      count_reg   <= count_next;
      overrun_reg <= overrun_next;
      mask_reg    <= mask_next;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_entry
      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
          mem_reg[gi] <= '0;
        else if (push && wr_ptr_reg == PTR_W'(gi))
          mem_reg[gi] <= in_data;
      end
    end
  endgenerate

  logic [31:0] head_word;
  logic [31:0] status_word;

  always_comb begin
    head_word = '0;
    if (not_empty)
      head_word[DATA_WIDTH-1:0] = mem_reg[rd_ptr_reg];
  end

  always_comb begin
    status_word             = '0;
    status_word[0]          = not_empty;
    status_word[1]          = overrun_reg;
    status_word[2]          = full;
    status_word[8 +: CNT_W] = count_reg;
  end

  always_comb begin
    readdata = '0;
    case (address)
      ADDR_DATA:   readdata = head_word;
      ADDR_STATUS: readdata = status_word;
      ADDR_MASK:   readdata = {30'd0, mask_reg};
      default:     readdata = '0;
    endcase
  end

  assign irq = (mask_reg[0] & not_empty) | (mask_reg[1] & overrun_reg);

  logic unused_writedata;
  assign unused_writedata = &{1'b0, writedata[31:2]};

endmodule

// File: tb/tb_nios2_uart_rx_pi.sv
// Directed bench for nios2_uart_rx_pi (DATA_WIDTH=8, DEPTH=4) with immediate-assertion checks.
module tb_nios2_uart_rx_pi;

  logic        clk;
  logic        reset_n;
  logic [1:0]  address;
  logic        chipselect;
  logic        read_n;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic [7:0]  in_data;
  logic        in_valid;
  logic        irq;

  int total = 0;
  int bad   = 0;

  nios2_uart_rx_pi #(.DATA_WIDTH(8), .DEPTH(4)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .address    (address),
    .chipselect (chipselect),
    .read_n     (read_n),
    .write_n    (write_n),
    .writedata  (writedata),
    .readdata   (readdata),
    .in_data    (in_data),
    .in_valid   (in_valid),
    .irq        (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    chipselect = 1'b0;
    read_n     = 1'b1;
    write_n    = 1'b1;
    in_valid   = 1'b0;
  endtask

  // Read one register; readdata is sampled mid-cycle, then the edge commits any pop.
  task automatic bus_read(input logic [1:0] a, input string tag, input logic [31:0] exp);
    @(negedge clk);
    address = a; chipselect = 1'b1; read_n = 1'b0;
    #1;
    $display("read  addr=%0d data=0x%08h", a, readdata);
    check(tag, readdata, exp);
    @(posedge clk); #1;
    idle();
  endtask

  task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
    @(negedge clk);
    address = a; chipselect = 1'b1; write_n = 1'b0; writedata = d;
    @(posedge clk); #1;
    $display("write addr=%0d data=0x%08h", a, d);
    idle();
  endtask

  task automatic push(input logic [7:0] d);
    @(negedge clk);
    in_valid = 1'b1; in_data = d;
    @(posedge clk); #1;
    $display("push  data=0x%02h", d);
    idle();
  endtask

  // Push and DATA read in the same cycle.
  task automatic push_pop(input logic [7:0] d, input string tag, input logic [31:0] exp);
    @(negedge clk);
    address = 2'd0; chipselect = 1'b1; read_n = 1'b0;
    in_valid = 1'b1; in_data = d;
    #1;
    $display("push  data=0x%02h with read data=0x%08h", d, readdata);
    check(tag, readdata, exp);
    @(posedge clk); #1;
    idle();
  endtask

  initial begin
    reset_n = 1'b0; address = 2'd0; writedata = '0; in_data = '0;
    idle();
    repeat (2) @(posedge clk);
    @(negedge clk); reset_n = 1'b1;
    #1;

    check("rst_irq", {31'd0, irq}, 32'd0);
    bus_read(2'd0, "rst_data",   32'h0);
    bus_read(2'd1, "rst_status", 32'h0);
    bus_read(2'd2, "rst_mask",   32'h0);
    bus_read(2'd3, "rst_resv",   32'h0);

    push(8'h5A);
    bus_read(2'd1, "one_status", 32'h0000_0101);
    bus_read(2'd0, "one_data",   32'h0000_005A);
    bus_read(2'd1, "one_empty",  32'h0000_0000);
    bus_read(2'd0, "empty_rd",   32'h0000_0000);
    bus_read(2'd1, "empty_rd_st", 32'h0000_0000);

    push(8'h11); push(8'h22); push(8'h33); push(8'h44);
    bus_read(2'd1, "full_status", 32'h0000_0405);
    push(8'h55);
    bus_read(2'd1, "ovr_status", 32'h0000_0407);
    bus_read(2'd0, "drain0", 32'h11);
    bus_read(2'd0, "drain1", 32'h22);
    bus_read(2'd0, "drain2", 32'h33);
    bus_read(2'd0, "drain3", 32'h44);
    bus_read(2'd1, "drained_status", 32'h0000_0002);
    bus_write(2'd1, 32'h2);
    bus_read(2'd1, "w1c_status", 32'h0000_0000);

    push(8'h11); push(8'h22); push(8'h33); push(8'h44);
    push_pop(8'h66, "fullpp_head", 32'h11);
    bus_read(2'd1, "fullpp_status", 32'h0000_0405);
    bus_read(2'd0, "fullpp_d1", 32'h22);
    bus_read(2'd0, "fullpp_d2", 32'h33);
    bus_read(2'd0, "fullpp_d3", 32'h44);
    bus_read(2'd0, "fullpp_d4", 32'h66);
    bus_read(2'd1, "fullpp_empty", 32'h0000_0000);

    bus_write(2'd2, 32'hFFFF_FFF1);
    bus_read(2'd2, "mask_rb", 32'h1);
    check("irq_idle", {31'd0, irq}, 32'd0);
    push(8'hA5);
    check("irq_avail", {31'd0, irq}, 32'd1);
    bus_read(2'd0, "irq_pop", 32'hA5);
    check("irq_clear", {31'd0, irq}, 32'd0);

    bus_write(2'd2, 32'h2);
    push(8'h01); push(8'h02); push(8'h03); push(8'h04);
    check("irq_full_noovr", {31'd0, irq}, 32'd0);
    push(8'h05);
    check("irq_ovr", {31'd0, irq}, 32'd1);
    bus_write(2'd1, 32'h2);
    check("irq_w1c", {31'd0, irq}, 32'd0);
    bus_read(2'd1, "w1c_full", 32'h0000_0405);

    @(negedge clk);
    in_valid = 1'b1; in_data = 8'h77;
    address = 2'd1; chipselect = 1'b1; write_n = 1'b0; writedata = 32'h2;
    @(posedge clk); #1;
    $display("push  data=0x77 with STATUS W1C");
    idle();
    bus_read(2'd1, "setwins_status", 32'h0000_0407);
    check("setwins_irq", {31'd0, irq}, 32'd1);
    bus_read(2'd0, "setwins_d0", 32'h01);
    bus_read(2'd0, "setwins_d1", 32'h02);
    bus_read(2'd0, "setwins_d2", 32'h03);
    bus_read(2'd0, "setwins_d3", 32'h04);
    bus_write(2'd1, 32'h2);
    bus_write(2'd2, 32'h0);
    bus_read(2'd1, "after_clr", 32'h0000_0000);

    push_pop(8'h7E, "emptypp_rd", 32'h0);
    bus_read(2'd1, "emptypp_status", 32'h0000_0101);
    bus_read(2'd0, "emptypp_data", 32'h7E);

    push(8'h80);
    for (int i = 1; i <= 20; i++) begin
      push_pop(8'(8'h80 + i), $sformatf("wrap%0d", i), 32'(8'h80 + i - 1));
    end
    bus_read(2'd1, "wrap_status", 32'h0000_0101);
    bus_read(2'd0, "wrap_last", 32'h94);

    bus_write(2'd2, 32'h3);
    push(8'hC1); push(8'hC2); push(8'hC3);
    check("pre_rst_irq", {31'd0, irq}, 32'd1);
    @(negedge clk);
    #2 reset_n = 1'b0;
    #1;
    check("async_rst_irq", {31'd0, irq}, 32'd0);
    address = 2'd1; #1;
    check("async_rst_status", readdata, 32'h0);
    address = 2'd2; #1;
    check("async_rst_mask", readdata, 32'h0);
    address = 2'd0; #1;
    check("async_rst_data", readdata, 32'h0);
    @(negedge clk); reset_n = 1'b1;
    bus_read(2'd1, "post_rst_status", 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
